display_write_bridge: RTL
=========================

# display_write_bridge

Memory-mapped write bridge between the CPU store path and the seven-segment display peripheral. It decodes CPU stores that hit the display window, buffers them in a small FIFO, and drains them one at a time onto the display's select/address/write-enable/data inputs at a paced rate. It also keeps the display select asserted continuously, because the display clears its digits and mask whenever select is low.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- GAP, 2, minimum idle cycles between consecutive display write pulses (≥0)
- BASE, 32'hFFFF_FC00, display window base; window is BASE..BASE+7

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Cpu_addr  in  32  store byte address
- Cpu_wdata  in  32  store data; only [15:0] used
- Cpu_write  in  1  store valid this cycle
- Cpu_stall  out  1  combinational; hit & FIFO full; CPU holds store
- Disp_select  out  1  display chip select, registered
- Disp_write_enable  out  1  one-cycle write pulse, registered
- Disp_address  out  3  display register offset, registered
- Disp_write_data  out  16  display write data, registered
- Pending  out  3  FIFO occupancy, 0..DEPTH
- Err  out  1  sticky: set by a misaligned window store

## Operation
- hit = Cpu_write & (Cpu_addr[31:3] == BASE[31:3]).
- Offset Cpu_addr[2:0]:
  - 0, 2, 4 queue {op=WR, offset, Cpu_wdata[15:0]}.
  - 6 queues {op=CLR}; data ignored.
  - Odd offsets are not queued; they set Err and do not stall.
- Stores outside the window are ignored.
- Push happens at the clock edge when hit & !full. A full FIFO never accepts, even if a pop occurs on the same edge.
- Drain FSM:
  - IDLE: if FIFO non-empty, pop the head at the edge and go to ISSUE.
  - ISSUE: one cycle. For WR: Disp_write_enable=1, address/data from entry, Disp_select=1. For CLR: Disp_select=0, Disp_write_enable=0. Next state is GAPW if GAP>0, else IDLE.
  - GAPW: count GAP cycles with Disp_write_enable=0, then IDLE.
- Disp_select is a sticky armed flag.
  - 0 after reset; becomes 1 in the first WR ISSUE cycle.
  - Stays 1 except during a CLR ISSUE cycle (low exactly one cycle).
  - After CLR it returns to 1 only if it had been armed before.
- Disp_address and Disp_write_data hold their last values when not issuing.
- Ordering is strict FIFO order; a CLR queued between writes takes effect between them.

## Timing
- Reset (async assert, sync-safe release): FIFO flushed, Pending=0, FSM=IDLE, Disp_select=0, Disp_write_enable=0, Disp_address=0, Disp_write_data=0, Err=0.
- Reset asserted mid-burst discards all queued entries; no partial pulse after release.
- Latency: a store accepted at edge E with an empty FIFO and FSM in IDLE produces its ISSUE cycle between E+1 and E+2.
- Throughput: one display write per (GAP+1) cycles.
- Pending is updated at each edge; a simultaneous push and pop leaves it unchanged.
- Cpu_stall depends on current-cycle inputs and the registered full flag only. There is no combinational path from FIFO pop to stall.
- Pointers are log2(DEPTH) bits with wrap-around; full/empty are derived from an occupancy counter of log2(DEPTH)+1 bits.

## Structure
- Shared package holds:
  - op encoding (WR=0, CLR=1)
  - display offsets (DIGITS_LO=0, DIGITS_HI=2, MASK=4, CLEAR=6)
  - FSM state enum (IDLE, ISSUE, GAPW)
  - BASE default
- One sub-module, bridge_fifo: a synchronous FIFO, DEPTH×20 bits ({op, offset[2:0], data[15:0]}), with push/pop/full/empty/count.
- The top level holds the decode, the FSM and the output registers.

## Test plan
- Reset: drive reset=0 mid-run → all outputs 0 immediately, Pending=0; after release, no Disp_write_enable pulse.
- Single write: store 0x1234 to 0xFFFFFC00 → next cycle Disp_select=1, Disp_write_enable=1 for exactly one cycle, Disp_address=0, Disp_write_data=0x1234.
- Burst: 6 back-to-back stores (GAP=2, DEPTH=4) to FC00/FC02/FC04 with data 1..6 → Cpu_stall asserts while Pending=4; all six issue in order, pulses exactly 3 cycles apart.
- Clear: write 0xABCD to FC02, then store to FC06 → ISSUE for 0xABCD, GAP, then Disp_select=0 for one cycle, then 1; no write pulse during the clear.
- Misaligned/out-of-window: store to 0xFFFFFC03 → Err=1, Pending unchanged; store to 0xFFFFFC10 → nothing queued, Err unchanged.
- Wrap-around: 10 spaced writes through DEPTH=4 → pointers wrap, data order preserved, Pending returns to 0.

Source files
------------

// File: rtl/display_write_bridge_pkg.sv
package display_write_bridge_pkg;

  typedef enum logic {
    OP_WR  = 1'b0,
    OP_CLR = 1'b1
  } op_e;

  localparam logic [2:0] OFF_DIGITS_LO = 3'd0;
  localparam logic [2:0] OFF_DIGITS_HI = 3'd2;
  localparam logic [2:0] OFF_MASK      = 3'd4;
  localparam logic [2:0] OFF_CLEAR     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAPW
  } state_e;

  localparam logic [31:0] DISP_BASE_DEFAULT = 32'hFFFF_FC00;

  typedef struct packed {
    op_e         op;
    logic [2:0]  offset;
    logic [15:0] data;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/display_write_bridge_fifo.sv
module bridge_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    pop_data = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/display_write_bridge.sv
module display_write_bridge
  import display_write_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2,
  parameter logic [31:0] BASE  = DISP_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Cpu_addr,
  input  logic [31:0] Cpu_wdata,
  input  logic        Cpu_write,
  output logic        Cpu_stall,
  output logic        Disp_select,
  output logic        Disp_write_enable,
  output logic [2:0]  Disp_address,
  output logic [15:0] Disp_write_data,
  output logic [2:0]  Pending,
  output logic        Err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  logic          hit, wr_store, clr_store, queue_store, odd_store;
  logic          full, empty, pop, ready;
  logic [CW-1:0] count;
  entry_t        push_entry, head;
  logic [ENTRY_W-1:0] head_bits;
  logic          unused_wdata_hi;

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          armed_q, armed_d;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic [2:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          err_q, err_d;

  assign unused_wdata_hi = ^Cpu_wdata[31:16];

  always_comb begin
    hit         = Cpu_write & (Cpu_addr[31:3] == BASE[31:3]);
    wr_store    = Cpu_addr[2:0] inside {OFF_DIGITS_LO, OFF_DIGITS_HI, OFF_MASK};
    clr_store   = (Cpu_addr[2:0] == OFF_CLEAR);
    queue_store = hit & (wr_store | clr_store);
    odd_store   = hit & Cpu_addr[0];
    push_entry.op     = clr_store ? OP_CLR : OP_WR;
    push_entry.offset = Cpu_addr[2:0];
    push_entry.data   = Cpu_wdata[15:0];
  end

  assign Cpu_stall = queue_store & full;

  bridge_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (queue_store),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign head = entry_t'(head_bits);

  // The pop decision is taken in the last idle cycle so the next ISSUE follows
  // the gap directly, giving one pulse every GAP+1 cycles.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    armed_d = armed_q;
    sel_d   = armed_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q | odd_store;
    pop     = 1'b0;
    ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_ISSUE: begin
        if (GAP == 0) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d   = '0;
          state_d = ST_GAPW;
        end
      end
      ST_GAPW: begin
        if (gap_q == GW'(GAP - 1)) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ready && !empty) begin
      pop     = 1'b1;
      state_d = ST_ISSUE;
      if (head.op == OP_CLR) begin
        sel_d = 1'b0;
      end else begin
        we_d    = 1'b1;
        sel_d   = 1'b1;
        armed_d = 1'b1;
        addr_d  = head.offset;
        data_d  = head.data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      armed_q <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      armed_q <= armed_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign Disp_select       = sel_q;
  assign Disp_write_enable = we_q;
  assign Disp_address      = addr_q;
  assign Disp_write_data   = data_q;
  assign Pending           = 3'(count);
  assign Err               = err_q;

endmodule
